// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states
// and the counter-width helper.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble counter; a single-nibble adder still needs one bit.
  function automatic int cnt_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle. The adder is the slave side, the
// operand source / result consumer is the master side.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
) ();

  localparam int W = 4 * NIBBLES;

  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CIN;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] SUM;
  logic         COUT;

  modport slave (
    input  IN_VALID, A, B, CIN, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT
  );

  modport master (
    output IN_VALID, A, B, CIN, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT
  );

endinterface

// File: rtl/nibble_serial_adder_ripple.sv
// Purely combinational 4-bit ripple-carry stage with bit-level ports.
module ripple_adder (
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic C0,
  output logic SA,
  output logic SB,
  output logic SC,
  output logic SD,
  output logic COUT
);

  logic [3:0] a_bits;
  logic [3:0] b_bits;
  logic [3:0] s_bits;
  logic [4:0] carry;

  assign a_bits   = {A3, A2, A1, A0};
  assign b_bits   = {B3, B2, B1, B0};
  assign carry[0] = C0;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign s_bits[gi]    = a_bits[gi] ^ b_bits[gi] ^ carry[gi];
    assign carry[gi + 1] = (a_bits[gi] & b_bits[gi]) |
                           (carry[gi] & (a_bits[gi] ^ b_bits[gi]));
  end

  assign {SD, SC, SB, SA} = s_bits;
  assign COUT             = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder that streams one nibble per clock through a single
// 4-bit ripple stage. Carry between nibbles lives only in carry_reg.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                  CLK,
  input logic                  RST,
  nibble_serial_adder_if.slave bus
);

  import adder_pkg::*;

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t           state_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic [W-1:0]     sum_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  // The single shared 4-bit stage always sees the low nibble of each operand.
  ripple_adder u_stage (
    .A0   (a_reg[0]),
    .A1   (a_reg[1]),
    .A2   (a_reg[2]),
    .A3   (a_reg[3]),
    .B0   (b_reg[0]),
    .B1   (b_reg[1]),
    .B2   (b_reg[2]),
    .B3   (b_reg[3]),
    .C0   (carry_reg),
    .SA   (nib_sum[0]),
    .SB   (nib_sum[1]),
    .SC   (nib_sum[2]),
    .SD   (nib_sum[3]),
    .COUT (nib_cout)
  );

  // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  if (NIBBLES == 1) begin : g_single
    assign sum_next = nib_sum;
  end else begin : g_multi
    assign sum_next = {nib_sum, sum_reg[W-1:NIBBLE_W]};
  end

  // Control FSM plus all datapath registers; handshake outputs are registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.IN_VALID) begin
            a_reg        <= bus.A;
            b_reg        <= bus.B;
            carry_reg    <= bus.CIN;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= ADD;
          end
        end
        ADD: begin
          sum_reg   <= sum_next;
          carry_reg <= nib_cout;
          a_reg     <= a_reg >> NIBBLE_W;
          b_reg     <= b_reg >> NIBBLE_W;
          cnt_reg   <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            cout_reg      <= nib_cout;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          // Result is held; new operands are only taken once back in IDLE.
          if (bus.OUT_READY) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IN_READY  = in_ready_reg;
  assign bus.OUT_VALID = out_valid_reg;
  assign bus.SUM       = sum_reg;
  assign bus.COUT      = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: vector table, randomized ops against an arithmetic
// model, and hand-written handshake / reset / parameter-corner sequences.
module tb_nibble_serial_adder;

  logic CLK;
  logic RST;

  nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();

  nibble_serial_adder #(.NIBBLES(4)) dut4 (.CLK(CLK), .RST(RST), .bus(bus4));
  nibble_serial_adder #(.NIBBLES(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full 4-nibble transaction with OUT_READY high; call at a negedge.
  task automatic do_add4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] exp_sum, input logic exp_cout);
    int lat;
    chk("in_ready_idle4", 32'(bus4.IN_READY), 32'd1);
    bus4.A = a; bus4.B = b; bus4.CIN = cin; bus4.IN_VALID = 1'b1;
    bus4.OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus4.IN_VALID = 1'b0;
    lat = 1;
    while (!bus4.OUT_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk("latency4", 32'(lat), 32'd5);
    chk("sum4", 32'(bus4.SUM), 32'(exp_sum));
    chk("cout4", 32'(bus4.COUT), 32'(exp_cout));
    $display("op4 a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d",
             a, b, cin, bus4.SUM, bus4.COUT, lat);
    @(negedge CLK);
    chk("out_valid_drop4", 32'(bus4.OUT_VALID), 32'd0);
    chk("in_ready_back4", 32'(bus4.IN_READY), 32'd1);
  endtask

  // Same for the single-nibble instance.
  task automatic do_add1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic [3:0] exp_sum, input logic exp_cout);
    int lat;
    chk("in_ready_idle1", 32'(bus1.IN_READY), 32'd1);
    bus1.A = a; bus1.B = b; bus1.CIN = cin; bus1.IN_VALID = 1'b1;
    bus1.OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus1.IN_VALID = 1'b0;
    lat = 1;
    while (!bus1.OUT_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk("latency1", 32'(lat), 32'd2);
    chk("sum1", 32'(bus1.SUM), 32'(exp_sum));
    chk("cout1", 32'(bus1.COUT), 32'(exp_cout));
    $display("op1 a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d",
             a, b, cin, bus1.SUM, bus1.COUT, lat);
    @(negedge CLK);
    chk("out_valid_drop1", 32'(bus1.OUT_VALID), 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    logic [16:0] model;
    logic [4:0]  model1;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] exp_q[$];
    logic [16:0] got_exp;
    int issued, received, last_t, cyc;

    checks = 0;
    errors = 0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    bus4.IN_VALID = 1'b0; bus4.A = '0; bus4.B = '0; bus4.CIN = 1'b0; bus4.OUT_READY = 1'b1;
    bus1.IN_VALID = 1'b0; bus1.A = '0; bus1.B = '0; bus1.CIN = 1'b0; bus1.OUT_READY = 1'b1;

    // Reset state
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_sum", 32'(bus4.SUM), 32'd0);
    chk("rst_cout", 32'(bus4.COUT), 32'd0);
    chk("rst_out_valid", 32'(bus4.OUT_VALID), 32'd0);
    chk("rst_in_ready", 32'(bus4.IN_READY), 32'd1);
    chk("rst_in_ready1", 32'(bus1.IN_READY), 32'd1);

    // Vector table
    for (int i = 0; i < 7; i++)
      do_add4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);

    // Randomized ops against plain arithmetic
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      model = 17'(ra) + 17'(rb) + 17'(rc);
      do_add4(ra, rb, rc, model[15:0], model[16]);
    end

    // Backpressure: result held while OUT_READY low; extra IN_VALID ignored
    bus4.OUT_READY = 1'b0;
    bus4.A = 16'h1111; bus4.B = 16'h2222; bus4.CIN = 1'b0; bus4.IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus4.IN_VALID = 1'b0;
    chk("bp_in_ready_add", 32'(bus4.IN_READY), 32'd0);
    bus4.A = 16'h7777; bus4.B = 16'h7777; bus4.IN_VALID = 1'b1;
    @(negedge CLK);
    bus4.IN_VALID = 1'b0;
    cyc = 0;
    while (!bus4.OUT_VALID && cyc < 20) begin
      chk("bp_in_ready_wait", 32'(bus4.IN_READY), 32'd0);
      @(negedge CLK);
      cyc++;
    end
    chk("bp_sum", 32'(bus4.SUM), 32'h3333);
    chk("bp_cout", 32'(bus4.COUT), 32'd0);
    bus4.IN_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("bp_hold_valid", 32'(bus4.OUT_VALID), 32'd1);
      chk("bp_hold_sum", 32'(bus4.SUM), 32'h3333);
      chk("bp_hold_cout", 32'(bus4.COUT), 32'd0);
      chk("bp_hold_in_ready", 32'(bus4.IN_READY), 32'd0);
    end
    bus4.IN_VALID = 1'b0;
    bus4.OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_release_valid", 32'(bus4.OUT_VALID), 32'd0);
    chk("bp_release_ready", 32'(bus4.IN_READY), 32'd1);
    @(negedge CLK);
    chk("bp_no_extra_op", 32'(bus4.OUT_VALID), 32'd0);
    chk("bp_sum_kept", 32'(bus4.SUM), 32'h3333);
    $display("backpressure sequence done");

    // Reset during the 2nd ADD cycle
    bus4.A = 16'hAAAA; bus4.B = 16'h1111; bus4.CIN = 1'b1; bus4.IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus4.IN_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_sum", 32'(bus4.SUM), 32'd0);
    chk("mid_rst_cout", 32'(bus4.COUT), 32'd0);
    chk("mid_rst_out_valid", 32'(bus4.OUT_VALID), 32'd0);
    chk("mid_rst_in_ready", 32'(bus4.IN_READY), 32'd1);
    $display("mid-operation reset done");
    do_add4(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

    // Single-nibble instance
    do_add1(4'h9, 4'h8, 1'b1, 4'h2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15)); rc = 1'($urandom);
      model1 = 5'(ra[3:0]) + 5'(rb[3:0]) + 5'(rc);
      do_add1(ra[3:0], rb[3:0], rc, model1[3:0], model1[4]);
    end

    // Back-to-back with IN_VALID held high and OUT_READY tied high
    bus4.OUT_READY = 1'b1;
    issued = 0; received = 0; last_t = -1; cyc = 0;
    while (received < 5 && cyc < 100) begin
      if (bus4.OUT_VALID) begin
        got_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
        chk("b2b_sum", 32'(bus4.SUM), 32'(got_exp[15:0]));
        chk("b2b_cout", 32'(bus4.COUT), 32'(got_exp[16]));
        if (last_t >= 0) chk("b2b_spacing", 32'(cyc - last_t), 32'd6);
        $display("b2b result %0d sum=%h cout=%0d cycle=%0d", received, bus4.SUM, bus4.COUT, cyc);
        last_t = cyc;
        received++;
      end
      if (bus4.IN_READY) begin
        if (issued < 5) begin
          ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
          bus4.A = ra; bus4.B = rb; bus4.CIN = rc; bus4.IN_VALID = 1'b1;
          exp_q.push_back(17'(ra) + 17'(rb) + 17'(rc));
          issued++;
        end else begin
          bus4.IN_VALID = 1'b0;
        end
      end
      @(negedge CLK);
      cyc++;
    end
    bus4.IN_VALID = 1'b0;
    chk("b2b_received", 32'(received), 32'd5);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
